scoreboard_commit_ctrl: RTL and testbench

//  In-order commit sequencer for the Scoreboard. Watches the head entry, pulses start_head,

---
 rtl/scoreboard_commit_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_scoreboard_commit_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_commit_ctrl.sv
// rtl/scoreboard_commit_ctrl.sv - in-order commit sequencer for the Scoreboard head entry
//
// Purpose: waits for the Scoreboard head to become ready, pulses sb_start_head, offers the
// head tag to the register-file write port (commit_valid/commit_ready), then pulses
// sb_committing to retire it. Mispredict flush requests are merged (oldest tag wins) and
// issued as single-cycle sb_flushing/sb_instr_to_flush pulses. A watchdog sets the sticky
// stall_err when no forward progress is made for STALL_LIMIT cycles.
//
// Ports:
//   clock, reset              clock; asynchronous active-low reset
//   sb_head_instr/_ready      Scoreboard head tag and ready flag
//   sb_is_empty               Scoreboard empty flag
//   sb_start_head             1-cycle pulse when a commit sequence starts
//   sb_committing             1-cycle pulse when the offered tag retires
//   sb_flushing               1-cycle flush pulse, sb_instr_to_flush valid with it
//   flush_req, flush_instr    mispredict flush request and first tag to discard
//   commit_valid/_instr/_ready  commit offer to the register-file write port
//   stall_err                 sticky watchdog error
//   commit_count, flush_count wrapping perf counters (only with COMMIT_PERF_EN)
//
// Optional feature macro: COMMIT_PERF_EN (adds CNT_W, commit_count, flush_count).
module scoreboard_commit_ctrl #(
  parameter int INSTR_W     = 32,
  parameter int STALL_LIMIT = 1024
`ifdef COMMIT_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] sb_head_instr,
  input  logic               sb_head_ready,
  input  logic               sb_is_empty,
  output logic               sb_start_head,
  output logic               sb_committing,
  output logic               sb_flushing,
  output logic [INSTR_W-1:0] sb_instr_to_flush,
  input  logic               flush_req,
  input  logic [INSTR_W-1:0] flush_instr,
  output logic               commit_valid,
  output logic [INSTR_W-1:0] commit_instr,
  input  logic               commit_ready,
  output logic               stall_err
`ifdef COMMIT_PERF_EN
  ,
  output logic [CNT_W-1:0]   commit_count,
  output logic [CNT_W-1:0]   flush_count
`endif
);

  localparam int WD_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_OFFER, S_RETIRE, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [INSTR_W-1:0]   pend_tag_q, pend_tag_d;
  logic                 start_q, start_d;
  logic                 committing_q, committing_d;
  logic                 flushing_q, flushing_d;
  logic [INSTR_W-1:0]   flush_tag_q, flush_tag_d;
  logic                 valid_q, valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 stall_err_q, stall_err_d;
  logic                 handshake;
  logic                 pend_eff;
  logic [INSTR_W-1:0]   pend_tag_eff;

  always_comb begin
    handshake    = valid_q & commit_ready;

    // A request arriving this cycle already counts as pending, so the FSM can react to it
    // at the coming edge. Two requests merge to the smaller (older) tag.
    pend_eff     = pend_q | flush_req;
    pend_tag_eff = pend_tag_q;
    if (flush_req && !(pend_q && (pend_tag_q < flush_instr))) begin
      pend_tag_eff = flush_instr;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pend_eff) state_d = S_FLUSH;
                else if (sb_head_ready && !sb_is_empty) state_d = S_START;
      S_START:  state_d = pend_eff ? S_FLUSH : S_OFFER;
      // A handshake in the same cycle as a flush request still commits; the flush waits.
      S_OFFER:  if (handshake) state_d = S_RETIRE;
                else if (pend_eff) state_d = S_FLUSH;
      S_RETIRE: state_d = pend_eff ? S_FLUSH : S_IDLE;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // The FLUSH cycle consumes the pending flush; a request arriving in it starts a new one.
    if (state_q == S_FLUSH) begin
      pend_d     = flush_req;
      pend_tag_d = flush_req ? flush_instr : pend_tag_q;
    end else begin
      pend_d     = pend_eff;
      pend_tag_d = pend_tag_eff;
    end

    // Outputs are registered copies of the next state.
    start_d      = (state_d == S_START);
    valid_d      = (state_d == S_OFFER);
    committing_d = (state_d == S_RETIRE);
    flushing_d   = (state_d == S_FLUSH);
    flush_tag_d  = (state_d == S_FLUSH) ? pend_tag_eff : '0;
    instr_d      = (state_q == S_START) ? sb_head_instr : instr_q;

    wd_d = wd_q;
    if (handshake || flushing_q || sb_is_empty) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(STALL_LIMIT)) begin
      wd_d = wd_q + WD_W'(1);
    end
    stall_err_d = stall_err_q | (wd_d == WD_W'(STALL_LIMIT));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      pend_tag_q   <= '0;
      start_q      <= 1'b0;
      committing_q <= 1'b0;
      flushing_q   <= 1'b0;
      flush_tag_q  <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      wd_q         <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_tag_q   <= pend_tag_d;
      start_q      <= start_d;
      committing_q <= committing_d;
      flushing_q   <= flushing_d;
      flush_tag_q  <= flush_tag_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      wd_q         <= wd_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign sb_start_head     = start_q;
  assign sb_committing     = committing_q;
  assign sb_flushing       = flushing_q;
  assign sb_instr_to_flush = flush_tag_q;
  assign commit_valid      = valid_q;
  assign commit_instr      = instr_q;
  assign stall_err         = stall_err_q;

`ifdef COMMIT_PERF_EN
  logic [CNT_W-1:0] commit_count_q, commit_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    commit_count_d = commit_count_q + CNT_W'(state_q == S_RETIRE);
    flush_count_d  = flush_count_q + CNT_W'(state_q == S_FLUSH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      commit_count_q <= commit_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign commit_count = commit_count_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_scoreboard_commit_ctrl.sv
// tb/tb_scoreboard_commit_ctrl.sv - self-checking bench for scoreboard_commit_ctrl
module tb_scoreboard_commit_ctrl;

  localparam int W   = 32;
  localparam int LIM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  sb_head_instr;
  logic          sb_head_ready;
  logic          sb_is_empty;
  logic          sb_start_head;
  logic          sb_committing;
  logic          sb_flushing;
  logic [W-1:0]  sb_instr_to_flush;
  logic          flush_req;
  logic [W-1:0]  flush_instr;
  logic          commit_valid;
  logic [W-1:0]  commit_instr;
  logic          commit_ready;
  logic          stall_err;
`ifdef COMMIT_PERF_EN
  logic [31:0]   commit_count;
  logic [31:0]   flush_count;
`endif

  scoreboard_commit_ctrl #(.INSTR_W(W), .STALL_LIMIT(LIM)) dut (
    .clock             (clock),
    .reset             (reset),
    .sb_head_instr     (sb_head_instr),
    .sb_head_ready     (sb_head_ready),
    .sb_is_empty       (sb_is_empty),
    .sb_start_head     (sb_start_head),
    .sb_committing     (sb_committing),
    .sb_flushing       (sb_flushing),
    .sb_instr_to_flush (sb_instr_to_flush),
    .flush_req         (flush_req),
    .flush_instr       (flush_instr),
    .commit_valid      (commit_valid),
    .commit_instr      (commit_instr),
    .commit_ready      (commit_ready),
    .stall_err         (stall_err)
`ifdef COMMIT_PERF_EN
    ,
    .commit_count      (commit_count),
    .flush_count       (flush_count)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected output pulses for the current cycle, the set of flush tags
  // requested since the last flush was issued, and a count of consecutive stalled cycles.
  bit          m_start, m_valid, m_commit, m_flush, m_err;
  logic [W-1:0] m_ctag, m_ftag;
  int          m_wd;
  logic [W-1:0] pq[$];
  int          m_ccnt, m_fcnt;
  int          seen_commit, seen_flush;
  logic [W-1:0] last_ftag;

  task automatic model_clear();
    m_start = 0; m_valid = 0; m_commit = 0; m_flush = 0; m_err = 0;
    m_ctag = '0; m_ftag = '0; m_wd = 0; m_ccnt = 0; m_fcnt = 0;
    pq.delete();
  endtask

  task automatic cyc(input bit hr, input bit emp, input logic [W-1:0] ht,
                     input bit cr, input bit fr, input logic [W-1:0] ft);
    bit idle, hs, ns, nv, nc, nf;
    logic [W-1:0] mn;
    sb_head_ready = hr; sb_is_empty = emp; sb_head_instr = ht;
    commit_ready = cr; flush_req = fr; flush_instr = ft;
    if (!reset) begin
      model_clear();
    end else begin
      if (m_commit) m_ccnt++;
      if (m_flush) m_fcnt++;
      hs = m_valid && cr;
      if (hs || m_flush || emp) m_wd = 0;
      else if (m_wd < LIM) m_wd++;
      if (m_wd >= LIM) m_err = 1;
      if (m_flush) pq.delete();
      if (fr) pq.push_back(ft);
      idle = !(m_start || m_valid || m_commit || m_flush);
      ns = 0; nv = 0; nc = 0; nf = 0;
      if (m_start) m_ctag = ht;
      if (idle) begin
        if (pq.size() > 0) nf = 1;
        else if (hr && !emp) ns = 1;
      end else if (m_start) begin
        if (pq.size() > 0) nf = 1; else nv = 1;
      end else if (m_valid) begin
        if (hs) nc = 1;
        else if (pq.size() > 0) nf = 1;
        else nv = 1;
      end else if (m_commit) begin
        if (pq.size() > 0) nf = 1;
      end
      if (nf) begin
        mn = pq[0];
        foreach (pq[i]) if (pq[i] < mn) mn = pq[i];
        m_ftag = mn;
      end
      m_start = ns; m_valid = nv; m_commit = nc; m_flush = nf;
    end
    @(posedge clock);
    #1;
    check("start_head", W'(sb_start_head), W'(m_start));
    check("commit_valid", W'(commit_valid), W'(m_valid));
    check("committing", W'(sb_committing), W'(m_commit));
    check("flushing", W'(sb_flushing), W'(m_flush));
    check("stall_err", W'(stall_err), W'(m_err));
    if (m_valid) check("commit_instr", commit_instr, m_ctag);
    if (m_flush) check("flush_tag", sb_instr_to_flush, m_ftag);
    if (!reset) begin
      check("rst_commit_instr", commit_instr, '0);
      check("rst_flush_tag", sb_instr_to_flush, '0);
    end
`ifdef COMMIT_PERF_EN
    check("commit_count", commit_count, W'(m_ccnt));
    check("flush_count", flush_count, W'(m_fcnt));
`endif
    if (sb_committing) seen_commit++;
    if (sb_flushing) begin
      seen_flush++;
      last_ftag = sb_instr_to_flush;
    end
  endtask

  initial begin
    reset = 1'b0;
    model_clear();
    // Reset held with the head ready: nothing may start.
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'd5, 1, 0, 0);
    reset = 1'b1;

    // Head not ready but Scoreboard not empty: watchdog trips after LIM cycles.
    for (int i = 0; i < LIM; i++) cyc(0, 0, 0, 0, 0, 0);
    check("stall_set", W'(stall_err), 1);

    // Tags 5,6,7 back to back with a zero-wait write port: three retires in 12 cycles.
    seen_commit = 0;
    for (int t = 0; t < 3; t++)
      for (int c = 0; c < 4; c++) cyc(1, 0, W'(5 + t), 1, 0, 0);
    check("b2b_retires", W'(seen_commit), 3);
    check("stall_sticky", W'(stall_err), 1);

    // Reset asserted while an offer is outstanding: outputs drop without a clock edge.
    cyc(1, 0, 32'd3, 0, 0, 0);
    cyc(0, 0, 32'd3, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check("async_valid", W'(commit_valid), 0);
    check("async_stall", W'(stall_err), 0);
    cyc(0, 1, 0, 0, 0, 0);
    reset = 1'b1;

    // Tag 8 held while the write port stalls for four cycles.
    seen_commit = 0;
    cyc(1, 0, 32'd8, 0, 0, 0);
    cyc(0, 1, 32'd8, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'd1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'd1, 1, 0, 0);
    check("stall_one_retire", W'(seen_commit), 1);

    // Flush of the offered tag with no handshake: offer abandoned, flush 9 next cycle.
    seen_commit = 0; seen_flush = 0;
    cyc(1, 1, 32'd9, 0, 0, 0);
    cyc(1, 0, 32'd9, 0, 0, 0);
    cyc(0, 0, 32'd9, 0, 0, 0);
    cyc(0, 0, 32'd9, 0, 1, 32'd9);
    check("flush_no_retire", W'(seen_commit), 0);
    check("flush9_tag", last_ftag, 32'd9);
    cyc(0, 1, 0, 0, 0, 0);
    // Same again but with the handshake in the flush cycle: retire first, then flush.
    cyc(1, 0, 32'd9, 0, 0, 0);
    cyc(0, 0, 32'd9, 0, 0, 0);
    cyc(0, 0, 32'd9, 1, 1, 32'd9);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("hs_then_flush_retires", W'(seen_commit), 1);
    check("hs_then_flush_flushes", W'(seen_flush), 2);

    // Requests 12 then 10 merge into one flush of the older tag.
    seen_flush = 0;
    cyc(1, 0, 32'd20, 0, 0, 0);
    cyc(0, 0, 32'd20, 0, 0, 0);
    cyc(0, 0, 32'd20, 1, 1, 32'd12);
    cyc(0, 0, 0, 0, 1, 32'd10);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("merge_one_flush", W'(seen_flush), 1);
    check("merge_tag", last_ftag, 32'd10);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, W'($urandom_range(0, 255)),
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, W'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
